// File: rtl/ifetch_unit_pkg.sv
// Shared types for the instruction-fetch front end: fetch FSM state and prefetch queue entry.
package ifetch_unit_pkg;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_REQ   = 2'd1,
      IF_DRAIN = 2'd2
   } ifetch_state_t;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
      logic        jump;
   } ifq_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO of fetch entries with push/pop/flush; flush wins over both push and pop.
module ifetch_queue
   import ifetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  ifq_entry_t               i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output ifq_entry_t               o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   ifq_entry_t       r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_push  = i_push && !i_flush;
   assign w_pop   = i_pop && !o_empty && !i_flush;

   // Entry storage carries no reset; the head mux below keeps outputs clean when empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head  = o_empty ? '0 : r_mem[r_rd];
   assign o_count = r_cnt;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: word-aligned imem read sequencer feeding a prefetch queue.
// Optional statistics counters are built when IFETCH_STATS_EN is defined.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        consume,
   output logic [31:0] word,
   output logic [31:0] word_pc,
   output logic        word_valid,
   output logic        word_jump,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic        imem_resp,
   input  logic [31:0] imem_rdata
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0] stat_bubbles,
   output logic [15:0] stat_redirects
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   ifetch_state_t    r_state;
   logic [31:0]      r_fa;
   logic [31:0]      r_pc_next;
   logic [31:0]      r_imem_addr;
   logic             r_pend_jump;
   logic             r_imem_read;

   ifq_entry_t       w_head;
   ifq_entry_t       w_push_data;
   logic [CW-1:0]    w_count;
   logic [CW-1:0]    w_cnt_next;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [31:0]      w_fa_inc;

   assign w_push      = (r_state == IF_REQ) && imem_resp && !redirect;
   assign w_pop       = consume && !w_empty && !redirect;
   assign w_fa_inc    = r_fa + 32'd4;
   assign w_push_data = {imem_rdata, r_pc_next, r_pend_jump};

   // Occupancy after this edge decides whether the next read may go out back-to-back.
   always_comb begin
      w_cnt_next = w_count;
      if (w_push && !w_pop)      w_cnt_next = w_count + CW'(1);
      else if (!w_push && w_pop) w_cnt_next = w_count - CW'(1);
   end

   ifetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (consume),
      .i_flush (redirect),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IF_IDLE;
         r_imem_read <= 1'b0;
         r_imem_addr <= '0;
         r_fa        <= word_align(RESET_PC);
         r_pc_next   <= RESET_PC;
         r_pend_jump <= 1'b1;
      end else if (redirect) begin
         r_fa        <= word_align(redirect_pc);
         r_pc_next   <= {redirect_pc[31:1], 1'b0};
         r_pend_jump <= 1'b1;
         // An outstanding read can never be aborted; its data is dropped instead.
         if (r_state != IF_IDLE) begin
            if (imem_resp) begin
               r_state     <= IF_IDLE;
               r_imem_read <= 1'b0;
            end else begin
               r_state     <= IF_DRAIN;
            end
         end
      end else begin
         case (r_state)
            IF_IDLE: begin
               if (!w_full) begin
                  r_state     <= IF_REQ;
                  r_imem_read <= 1'b1;
                  r_imem_addr <= r_fa;
               end
            end
            IF_REQ: begin
               if (imem_resp) begin
                  r_pend_jump <= 1'b0;
                  r_fa        <= w_fa_inc;
                  r_pc_next   <= w_fa_inc;
                  if (w_cnt_next < CW'(DEPTH)) begin
                     r_imem_addr <= w_fa_inc;
                  end else begin
                     r_state     <= IF_IDLE;
                     r_imem_read <= 1'b0;
                  end
               end
            end
            IF_DRAIN: begin
               if (imem_resp) begin
                  r_state     <= IF_IDLE;
                  r_imem_read <= 1'b0;
               end
            end
            default: begin
               r_state     <= IF_IDLE;
               r_imem_read <= 1'b0;
            end
         endcase
      end
   end

   assign word         = w_head.word;
   assign word_pc      = w_head.pc;
   assign word_jump    = w_head.jump;
   assign word_valid   = !w_empty;
   assign imem_read    = r_imem_read;
   assign imem_address = r_imem_addr;

`ifdef IFETCH_STATS_EN
   logic [31:0] r_bubbles;
   logic [15:0] r_redirects;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bubbles   <= '0;
         r_redirects <= '0;
      end else begin
         if (w_empty)  r_bubbles   <= r_bubbles + 32'd1;
         if (redirect) r_redirects <= sat_inc16(r_redirects);
      end
   end

   assign stat_bubbles   = r_bubbles;
   assign stat_redirects = r_redirects;
`endif

endmodule
